// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access unit: CSR addresses, SYSTEM
// instruction encodings, sequencer states and the read-modify-write helper.
package csr_pkg;

    localparam int XLEN   = 32;
    localparam int CSR_AW = 12;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [2:0] F3_PRIV   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_RSVD   = 3'b100;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [31:0] INSTR_ECALL = 32'h0000_0073;
    localparam logic [31:0] INSTR_MRET  = 32'h3020_0073;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        TRAP,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_RW,
        OP_RS,
        OP_RC,
        OP_ECALL,
        OP_MRET,
        OP_ILLEGAL
    } op_kind_e;

    // New CSR value for a Zicsr op: plain bitwise combination of old value and operand.
    function automatic logic [XLEN-1:0] csr_apply(input op_kind_e kind,
                                                  input logic [XLEN-1:0] old_val,
                                                  input logic [XLEN-1:0] operand);
        logic [XLEN-1:0] result;
        case (kind)
            OP_RW:   result = operand;
            OP_RS:   result = old_val | operand;
            OP_RC:   result = old_val & ~operand;
            default: result = old_val;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/csr_access_unit_if.sv
// Bundles the issue handshake, the CSR file port and the result port of the
// CSR access unit. The slave side is the unit; the master side is the
// surrounding pipeline plus CSR file.
interface csr_access_unit_if
    import csr_pkg::*;
#(
    parameter int IF_XLEN   = XLEN,
    parameter int IF_CSR_AW = CSR_AW
) ();

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instr;
    logic [IF_XLEN-1:0]   pc;
    logic [IF_XLEN-1:0]   rs1_data;

    logic                 r_csr_en;
    logic [IF_CSR_AW-1:0] r_csr_addr;
    logic [IF_XLEN-1:0]   r_csr_data;
    logic                 w_csr_en;
    logic [IF_CSR_AW-1:0] w_csr_addr;
    logic [IF_XLEN-1:0]   w_csr_data;
    logic                 finish;
    logic [IF_XLEN-1:0]   csr_pc;
    logic                 jump_ecall;
    logic                 jump_mret;

    logic                 out_valid;
    logic                 out_ready;
    logic                 rd_wen;
    logic [4:0]           rd_addr;
    logic [IF_XLEN-1:0]   rd_data;
    logic                 redirect_valid;
    logic [IF_XLEN-1:0]   redirect_pc;
    logic                 illegal;

    modport slave (
        input  in_valid, instr, pc, rs1_data, r_csr_data, out_ready,
        output in_ready, r_csr_en, r_csr_addr, w_csr_en, w_csr_addr, w_csr_data,
               finish, csr_pc, jump_ecall, jump_mret, out_valid, rd_wen, rd_addr,
               rd_data, redirect_valid, redirect_pc, illegal
    );

    modport master (
        output in_valid, instr, pc, rs1_data, r_csr_data, out_ready,
        input  in_ready, r_csr_en, r_csr_addr, w_csr_en, w_csr_addr, w_csr_data,
               finish, csr_pc, jump_ecall, jump_mret, out_valid, rd_wen, rd_addr,
               rd_data, redirect_valid, redirect_pc, illegal
    );

endinterface

// File: rtl/csr_op_decode.sv
// Combinational classification of a SYSTEM instruction into the operation the
// CSR access unit will sequence.
module csr_op_decode
    import csr_pkg::*;
(
    input  logic [31:0] instr_i,
    output op_kind_e    kind_o,
    output logic        imm_o,
    output logic        write_suppress_o,
    output logic        illegal_o
);

    // Set/clear with a zero rs1/zimm field must not write, so that read-only CSRs can be read safely.
    always_comb begin
        kind_o           = OP_ILLEGAL;
        imm_o            = instr_i[14];
        write_suppress_o = 1'b0;
        case (instr_i[14:12])
            F3_PRIV: begin
                if (instr_i == INSTR_ECALL) begin
                    kind_o = OP_ECALL;
                end else if (instr_i == INSTR_MRET) begin
                    kind_o = OP_MRET;
                end else begin
                    kind_o = OP_ILLEGAL;
                end
            end
            F3_CSRRW, F3_CSRRWI: kind_o = OP_RW;
            F3_CSRRS, F3_CSRRSI: begin
                kind_o           = OP_RS;
                write_suppress_o = (instr_i[19:15] == 5'd0);
            end
            F3_CSRRC, F3_CSRRCI: begin
                kind_o           = OP_RC;
                write_suppress_o = (instr_i[19:15] == 5'd0);
            end
            default: kind_o = OP_ILLEGAL;
        endcase
        illegal_o = (kind_o == OP_ILLEGAL);
    end

endmodule

// File: rtl/csr_access_unit.sv
// CSR access unit: accepts one SYSTEM instruction at a time, performs the
// CSR read-modify-write or trap/return request, and presents a writeback or
// redirect result until the consumer takes it.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int P_XLEN   = XLEN,
    parameter int P_CSR_AW = CSR_AW
) (
    input  logic               clk,
    input  logic               rst,
    csr_access_unit_if.slave   bus
);

    state_e              state_q, state_d;
    op_kind_e            kind_q, kind_d;
    logic                suppress_q, suppress_d;
    logic [P_CSR_AW-1:0] csr_addr_q, csr_addr_d;
    logic [4:0]          rd_q, rd_d;
    logic [P_XLEN-1:0]   pc_q, pc_d;
    logic [P_XLEN-1:0]   operand_q, operand_d;
    logic [P_XLEN-1:0]   old_q, old_d;
    logic [P_XLEN-1:0]   redirect_q, redirect_d;

    op_kind_e dec_kind;
    logic     dec_imm;
    logic     dec_suppress;
    logic     dec_illegal;
    logic     is_zicsr;
    logic     is_trap;

    csr_op_decode u_decode (
        .instr_i          (bus.instr),
        .kind_o           (dec_kind),
        .imm_o            (dec_imm),
        .write_suppress_o (dec_suppress),
        .illegal_o        (dec_illegal)
    );

    assign is_zicsr = (kind_q == OP_RW) || (kind_q == OP_RS) || (kind_q == OP_RC);
    assign is_trap  = (kind_q == OP_ECALL) || (kind_q == OP_MRET);

    // State and latched operands; reset drops straight back to IDLE so no strobe can follow it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            kind_q     <= OP_RW;
            suppress_q <= 1'b0;
            csr_addr_q <= '0;
            rd_q       <= '0;
            pc_q       <= '0;
            operand_q  <= '0;
            old_q      <= '0;
            redirect_q <= '0;
        end else begin
            state_q    <= state_d;
            kind_q     <= kind_d;
            suppress_q <= suppress_d;
            csr_addr_q <= csr_addr_d;
            rd_q       <= rd_d;
            pc_q       <= pc_d;
            operand_q  <= operand_d;
            old_q      <= old_d;
            redirect_q <= redirect_d;
        end
    end

    // Sequencing: Zicsr goes through READ and WRITE, ECALL/MRET through TRAP, illegal straight to DONE.
    always_comb begin
        state_d    = state_q;
        kind_d     = kind_q;
        suppress_d = suppress_q;
        csr_addr_d = csr_addr_q;
        rd_d       = rd_q;
        pc_d       = pc_q;
        operand_d  = operand_q;
        old_d      = old_q;
        redirect_d = redirect_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    kind_d     = dec_kind;
                    suppress_d = dec_suppress;
                    csr_addr_d = bus.instr[31:20];
                    rd_d       = bus.instr[11:7];
                    pc_d       = bus.pc;
                    operand_d  = dec_imm ? {{(P_XLEN-5){1'b0}}, bus.instr[19:15]} : bus.rs1_data;
                    old_d      = '0;
                    redirect_d = '0;
                    if (dec_illegal) begin
                        state_d = DONE;
                    end else if ((dec_kind == OP_ECALL) || (dec_kind == OP_MRET)) begin
                        state_d = TRAP;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                old_d   = bus.r_csr_data;
                state_d = WRITE;
            end
            WRITE: state_d = DONE;
            TRAP: begin
                redirect_d = bus.r_csr_data;
                state_d    = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are a pure function of the current state so each strobe lasts exactly one state.
    always_comb begin
        bus.in_ready       = 1'b0;
        bus.r_csr_en       = 1'b0;
        bus.r_csr_addr     = '0;
        bus.w_csr_en       = 1'b0;
        bus.w_csr_addr     = '0;
        bus.w_csr_data     = '0;
        bus.finish         = 1'b0;
        bus.csr_pc         = '0;
        bus.jump_ecall     = 1'b0;
        bus.jump_mret      = 1'b0;
        bus.out_valid      = 1'b0;
        bus.rd_wen         = 1'b0;
        bus.rd_addr        = '0;
        bus.rd_data        = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.illegal        = 1'b0;
        case (state_q)
            IDLE: bus.in_ready = ~rst;
            READ: begin
                bus.r_csr_en   = 1'b1;
                bus.r_csr_addr = csr_addr_q;
            end
            WRITE: begin
                bus.w_csr_en   = ~suppress_q;
                bus.finish     = ~suppress_q;
                bus.w_csr_addr = csr_addr_q;
                bus.w_csr_data = csr_apply(kind_q, old_q, operand_q);
            end
            TRAP: begin
                bus.jump_ecall = (kind_q == OP_ECALL);
                bus.jump_mret  = (kind_q == OP_MRET);
                bus.csr_pc     = (kind_q == OP_ECALL) ? pc_q : '0;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (is_zicsr) begin
                    bus.rd_wen  = (rd_q != 5'd0);
                    bus.rd_addr = rd_q;
                    bus.rd_data = old_q;
                end else if (is_trap) begin
                    bus.redirect_valid = 1'b1;
                    bus.redirect_pc    = redirect_q;
                end else begin
                    bus.illegal = 1'b1;
                end
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_csr_access_unit.sv
// Bench for csr_access_unit: a behavioural CSR file answers the unit's
// requests, and an independent reference CSR image predicts every result.
module tb_csr_access_unit;

    logic clk;
    logic rst;

    csr_access_unit_if bus ();

    csr_access_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] csrFile [0:4095];
    logic [31:0] refCsr  [0:4095];

    int totalChecks;
    int badChecks;

    int          wCount;
    logic [11:0] lastWAddr;
    logic [31:0] lastWData;
    int          ecallCount;
    int          mretCount;
    logic [31:0] lastCsrPc;
    int          finishBad;

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // CSR file read port: trap vector or return address during trap requests, else addressed CSR.
    assign bus.r_csr_data = bus.jump_ecall ? csrFile[12'h305] :
                            bus.jump_mret  ? csrFile[12'h341] :
                            bus.r_csr_en   ? csrFile[bus.r_csr_addr] : 32'h0;

    // CSR file commits writes and records mepc on an ECALL request.
    always @(posedge clk) begin
        if (!rst) begin
            if (bus.w_csr_en) csrFile[bus.w_csr_addr] <= bus.w_csr_data;
            if (bus.jump_ecall) csrFile[12'h341] <= bus.csr_pc;
        end
    end

    // Strobe monitor sampling on the falling edge.
    always @(negedge clk) begin
        if (bus.w_csr_en === 1'b1) begin
            wCount++;
            lastWAddr = bus.w_csr_addr;
            lastWData = bus.w_csr_data;
        end
        if (bus.finish !== bus.w_csr_en) finishBad++;
        if (bus.jump_ecall === 1'b1) begin
            ecallCount++;
            lastCsrPc = bus.csr_pc;
        end
        if (bus.jump_mret === 1'b1) mretCount++;
    end

    // Hard stop in case the design never answers.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog observed=timeout expected=completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        assert (observed === expected)
        else begin
            badChecks++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mkCsr(input logic [2:0] f3, input logic [11:0] addr,
                                          input logic [4:0] rs1f, input logic [4:0] rdf);
        return {addr, rs1f, f3, rdf, 7'b1110011};
    endfunction

    task automatic applyStimulus(input logic [31:0] instrW, input logic [31:0] pcV,
                                 input logic [31:0] rs1V, input int readyDelay);
        logic [2:0]  f3;
        logic [11:0] csrA;
        logic [4:0]  rs1f;
        logic [4:0]  rdf;
        logic [31:0] operand;
        logic [31:0] oldV;
        logic [31:0] newV;
        logic        zicsr;
        logic        trap;
        logic        expWrite;
        logic        expIllegal;
        logic [31:0] expRedirect;
        int          expLat;
        int          expEcall;
        int          expMret;
        int          n;

        f3 = instrW[14:12];
        csrA = instrW[31:20];
        rs1f = instrW[19:15];
        rdf = instrW[11:7];
        zicsr = 1'b0;
        trap = 1'b0;
        expWrite = 1'b0;
        expIllegal = 1'b0;
        expRedirect = 32'h0;
        expEcall = 0;
        expMret = 0;
        oldV = 32'h0;
        newV = 32'h0;
        if (instrW == 32'h0000_0073) begin
            trap = 1'b1;
            expEcall = 1;
            expRedirect = refCsr[12'h305];
            refCsr[12'h341] = pcV;
            expLat = 2;
        end else if (instrW == 32'h3020_0073) begin
            trap = 1'b1;
            expMret = 1;
            expRedirect = refCsr[12'h341];
            expLat = 2;
        end else if (f3 == 3'b000 || f3 == 3'b100) begin
            expIllegal = 1'b1;
            expLat = 1;
        end else begin
            zicsr = 1'b1;
            expLat = 3;
            operand = f3[2] ? {27'h0, rs1f} : rs1V;
            oldV = refCsr[csrA];
            if (f3[1:0] == 2'b01) begin
                newV = operand;
                expWrite = 1'b1;
            end else if (f3[1:0] == 2'b10) begin
                newV = oldV | operand;
                expWrite = (rs1f != 5'd0);
            end else begin
                newV = oldV & ~operand;
                expWrite = (rs1f != 5'd0);
            end
            if (expWrite) refCsr[csrA] = newV;
        end

        @(negedge clk);
        wCount = 0;
        ecallCount = 0;
        mretCount = 0;
        lastCsrPc = 32'h0;
        finishBad = 0;
        checkOutput("in_ready_idle", {31'h0, bus.in_ready}, 32'h1);
        bus.instr = instrW;
        bus.pc = pcV;
        bus.rs1_data = rs1V;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.instr = $urandom;
        bus.rs1_data = $urandom;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 16) begin
            checkOutput("busy_in_ready", {31'h0, bus.in_ready}, 32'h0);
            @(negedge clk);
            n++;
        end
        checkOutput("latency", n, expLat);
        for (int i = 0; i < readyDelay; i++) begin
            checkOutput("hold_out_valid", {31'h0, bus.out_valid}, 32'h1);
            checkOutput("hold_in_ready", {31'h0, bus.in_ready}, 32'h0);
            if (zicsr) checkOutput("hold_rd_data", bus.rd_data, oldV);
            if (trap) checkOutput("hold_redirect_pc", bus.redirect_pc, expRedirect);
            @(negedge clk);
        end
        checkOutput("rd_wen", {31'h0, bus.rd_wen}, {31'h0, zicsr && (rdf != 5'd0)});
        checkOutput("redirect_valid", {31'h0, bus.redirect_valid}, {31'h0, trap});
        checkOutput("illegal", {31'h0, bus.illegal}, {31'h0, expIllegal});
        if (zicsr) begin
            checkOutput("rd_data", bus.rd_data, oldV);
            checkOutput("rd_addr", {27'h0, bus.rd_addr}, {27'h0, rdf});
        end
        if (trap) checkOutput("redirect_pc", bus.redirect_pc, expRedirect);
        checkOutput("w_csr_count", wCount, expWrite ? 1 : 0);
        if (expWrite) begin
            checkOutput("w_csr_addr", {20'h0, lastWAddr}, {20'h0, csrA});
            checkOutput("w_csr_data", lastWData, newV);
        end
        checkOutput("finish_match", finishBad, 0);
        checkOutput("ecall_count", ecallCount, expEcall);
        checkOutput("mret_count", mretCount, expMret);
        if (expEcall != 0) checkOutput("csr_pc", lastCsrPc, pcV);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("out_valid_clear", {31'h0, bus.out_valid}, 32'h0);
    endtask

    initial begin
        logic [2:0]  f3List [6];
        logic [11:0] addrList [5];
        logic [31:0] instrW;
        int          pick;

        f3List = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};
        addrList = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
        totalChecks = 0;
        badChecks = 0;
        for (int i = 0; i < 4096; i++) begin
            csrFile[i] = 32'h0;
            refCsr[i] = 32'h0;
        end
        csrFile[12'h300] = 32'h1800;
        refCsr[12'h300] = 32'h1800;

        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.instr = 32'h0;
        bus.pc = 32'h0;
        bus.rs1_data = 32'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_in_ready", {31'h0, bus.in_ready}, 32'h1);
        checkOutput("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("rst_w_csr_en", {31'h0, bus.w_csr_en}, 32'h0);
        checkOutput("rst_r_csr_en", {31'h0, bus.r_csr_en}, 32'h0);
        checkOutput("rst_rd_wen", {31'h0, bus.rd_wen}, 32'h0);
        checkOutput("rst_rd_data", bus.rd_data, 32'h0);
        checkOutput("rst_redirect_valid", {31'h0, bus.redirect_valid}, 32'h0);
        checkOutput("rst_illegal", {31'h0, bus.illegal}, 32'h0);

        $display("[TB] directed CSR ops");
        applyStimulus(mkCsr(3'b001, 12'h305, 5'd1, 5'd5), 32'h8000_0000, 32'h8000_0100, 0);
        applyStimulus(mkCsr(3'b010, 12'h300, 5'd0, 5'd6), 32'h8000_0004, 32'hFFFF_FFFF, 0);
        applyStimulus(mkCsr(3'b101, 12'h341, 5'd15, 5'd0), 32'h8000_0008, 32'h0, 0);
        applyStimulus(mkCsr(3'b111, 12'h341, 5'd3, 5'd7), 32'h8000_000C, 32'h0, 1);

        $display("[TB] trap and return");
        applyStimulus(32'h0000_0073, 32'h8000_0040, 32'h0, 0);
        applyStimulus(32'h3020_0073, 32'h8000_0100, 32'h0, 0);

        $display("[TB] backpressure and illegal");
        applyStimulus(mkCsr(3'b011, 12'h300, 5'd2, 5'd9), 32'h8000_0044, 32'h0000_0800, 4);
        applyStimulus(mkCsr(3'b100, 12'h300, 5'd2, 5'd9), 32'h8000_0048, 32'h1234_5678, 2);
        applyStimulus(32'h1050_0073, 32'h8000_004C, 32'h0, 0);

        $display("[TB] reset during WRITE");
        @(negedge clk);
        wCount = 0;
        bus.instr = mkCsr(3'b001, 12'h340, 5'd4, 5'd3);
        bus.pc = 32'h8000_0050;
        bus.rs1_data = 32'hDEAD_BEEF;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("rstmid_w_csr_en", {31'h0, bus.w_csr_en}, 32'h0);
        checkOutput("rstmid_finish", {31'h0, bus.finish}, 32'h0);
        checkOutput("rstmid_w_csr_data", bus.w_csr_data, 32'h0);
        checkOutput("rstmid_out_valid", {31'h0, bus.out_valid}, 32'h0);
        checkOutput("rstmid_in_ready", {31'h0, bus.in_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstmid_in_ready_after", {31'h0, bus.in_ready}, 32'h1);
        @(negedge clk);
        checkOutput("rstmid_no_write", wCount, 0);
        checkOutput("rstmid_csr_unchanged", csrFile[12'h340], refCsr[12'h340]);

        $display("[TB] randomized sequence");
        for (int k = 0; k < 60; k++) begin
            pick = $urandom_range(0, 15);
            if (pick == 0) begin
                instrW = 32'h0000_0073;
            end else if (pick == 1) begin
                instrW = 32'h3020_0073;
            end else if (pick == 2) begin
                instrW = mkCsr(3'b100, addrList[$urandom_range(0, 4)], 5'($urandom), 5'($urandom));
            end else begin
                instrW = mkCsr(f3List[$urandom_range(0, 5)], addrList[$urandom_range(0, 4)],
                               ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                               5'($urandom));
            end
            applyStimulus(instrW, {$urandom, 2'b00} , $urandom, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
